// File: rtl/ram_dp_clr.sv
// True dual-port synchronous RAM with active-low write enables, a hardware fill
// sequencer, selectable read-during-write behaviour and a write-collision flag.
module ram_dp_clr #(
  parameter int            DW       = 8,
  parameter int            AW       = 11,
  parameter logic [DW-1:0] FILL     = {DW{1'b0}},
  parameter int            RDW_MODE = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] data_a,
  input  logic [AW-1:0] addr_a,
  input  logic          we_a,
  output logic [DW-1:0] q_a,
  input  logic [DW-1:0] data_b,
  input  logic [AW-1:0] addr_b,
  input  logic          we_b,
  output logic [DW-1:0] q_b,
  input  logic          clr_req,
  output logic          busy,
  output logic          collision
);

  localparam int            DEPTH    = 1 << AW;
  localparam logic [AW-1:0] PTR_LAST = {AW{1'b1}};
  localparam logic [AW-1:0] PTR_ONE  = AW'(1'b1);
  localparam bit            NEW_DATA = (RDW_MODE == 0);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  logic [DW-1:0] mem_r [DEPTH];
  state_t        state_r;
  logic [AW-1:0] ptr_r;

  logic          run_s;
  logic          wr_a_s;
  logic          wr_b_s;
  logic          coll_s;
  logic [DW-1:0] rd_a_s;
  logic [DW-1:0] rd_b_s;

  // Port qualification; a clr_req edge discards any port write presented with it
  always_comb begin
    run_s  = !reset && (state_r == ST_RUN) && !clr_req;
    wr_a_s = run_s && !we_a;
    wr_b_s = run_s && !we_b;
    coll_s = wr_a_s && wr_b_s && (addr_a == addr_b);
    // Array reads see pre-edge contents, so cross-port reads always return old data
    rd_a_s = (!we_a && NEW_DATA) ? data_a : mem_r[addr_a];
    rd_b_s = (!we_b && NEW_DATA) ? data_b : mem_r[addr_b];
  end

  // Array update: sweep fill while clearing, else port writes with port A ordered last so it wins
  always_ff @(posedge clk) begin
    if (!reset && (state_r == ST_CLEAR)) begin
      mem_r[ptr_r] <= FILL;
    end else begin
      if (wr_b_s) begin
        mem_r[addr_b] <= data_b;
      end
      if (wr_a_s) begin
        mem_r[addr_a] <= data_a;
      end
    end
  end

  // Sequencer state, clear pointer and all registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_CLEAR;
      ptr_r     <= {AW{1'b0}};
      busy      <= 1'b1;
      q_a       <= {DW{1'b0}};
      q_b       <= {DW{1'b0}};
      collision <= 1'b0;
    end else begin
      case (state_r)
        ST_CLEAR: begin
          q_a       <= {DW{1'b0}};
          q_b       <= {DW{1'b0}};
          collision <= 1'b0;
          ptr_r     <= ptr_r + PTR_ONE;
          if (ptr_r == PTR_LAST) begin
            state_r <= ST_RUN;
            busy    <= 1'b0;
          end else begin
            state_r <= ST_CLEAR;
            busy    <= 1'b1;
          end
        end
        ST_RUN: begin
          if (clr_req) begin
            state_r   <= ST_CLEAR;
            ptr_r     <= {AW{1'b0}};
            busy      <= 1'b1;
            q_a       <= {DW{1'b0}};
            q_b       <= {DW{1'b0}};
            collision <= 1'b0;
          end else begin
            state_r   <= ST_RUN;
            busy      <= 1'b0;
            q_a       <= rd_a_s;
            q_b       <= rd_b_s;
            collision <= coll_s;
          end
        end
        default: begin
          state_r   <= ST_CLEAR;
          ptr_r     <= {AW{1'b0}};
          busy      <= 1'b1;
          q_a       <= {DW{1'b0}};
          q_b       <= {DW{1'b0}};
          collision <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_dp_clr.sv
// Scoreboard bench for ram_dp_clr: two instances (new-data and old-data
// read-during-write) share stimulus; a monitor pops expectations each cycle.
module tb_ram_dp_clr;

  logic       clk = 1'b0;
  logic       reset;
  logic       clr_req;
  logic       we_a;
  logic       we_b;
  logic [3:0] addr_a;
  logic [3:0] addr_b;
  logic [7:0] data_a;
  logic [7:0] data_b;
  logic [7:0] q_a0, q_b0, q_a1, q_b1;
  logic       busy0, busy1, coll0, coll1;

  always #5 clk = ~clk;

  ram_dp_clr #(.DW(8), .AW(4), .FILL(8'hA5), .RDW_MODE(0)) u_dut0 (
    .clk(clk), .reset(reset),
    .data_a(data_a), .addr_a(addr_a), .we_a(we_a), .q_a(q_a0),
    .data_b(data_b), .addr_b(addr_b), .we_b(we_b), .q_b(q_b0),
    .clr_req(clr_req), .busy(busy0), .collision(coll0)
  );

  ram_dp_clr #(.DW(8), .AW(4), .FILL(8'hA5), .RDW_MODE(1)) u_dut1 (
    .clk(clk), .reset(reset),
    .data_a(data_a), .addr_a(addr_a), .we_a(we_a), .q_a(q_a1),
    .data_b(data_b), .addr_b(addr_b), .we_b(we_b), .q_b(q_b1),
    .clr_req(clr_req), .busy(busy1), .collision(coll1)
  );

  typedef struct {
    string      nm;
    logic [3:0] chk;   // [0] q_a, [1] q_b, [2] busy, [3] collision
    logic [7:0] qa0, qa1, qb0, qb1;
    logic       bz, co;
  } exp_t;

  localparam logic [3:0] C_ALL = 4'b1111;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Drive one cycle of inputs before the edge and queue the response expected after it
  task automatic step(input string nm, input logic rst, input logic clr,
                      input logic wa, input logic [3:0] aa, input logic [7:0] da,
                      input logic wb, input logic [3:0] ab, input logic [7:0] db,
                      input logic [3:0] chk,
                      input logic [7:0] qa0, input logic [7:0] qa1,
                      input logic [7:0] qb0, input logic [7:0] qb1,
                      input logic bz, input logic co);
    exp_t e;
    @(negedge clk);
    reset   = rst;
    clr_req = clr;
    we_a    = wa;
    addr_a  = aa;
    data_a  = da;
    we_b    = wb;
    addr_b  = ab;
    data_b  = db;
    e.nm  = nm;
    e.chk = chk;
    e.qa0 = qa0;
    e.qa1 = qa1;
    e.qb0 = qb0;
    e.qb1 = qb1;
    e.bz  = bz;
    e.co  = co;
    sb.push_back(e);
  endtask

  task automatic rd(input string nm, input logic [3:0] aa, input logic [3:0] ab,
                    input logic [7:0] qa, input logic [7:0] qb);
    step(nm, 1'b0, 1'b0, 1'b1, aa, 8'h00, 1'b1, ab, 8'h00, C_ALL, qa, qa, qb, qb, 1'b0, 1'b0);
  endtask

  task automatic busy_step(input string nm, input logic rst, input logic clr,
                           input logic wa, input logic [3:0] aa, input logic [7:0] da,
                           input logic wb, input logic [3:0] ab, input logic [7:0] db,
                           input logic bz);
    step(nm, rst, clr, wa, aa, da, wb, ab, db, C_ALL, 8'h00, 8'h00, 8'h00, 8'h00, bz, 1'b0);
  endtask

  // Monitor: one expectation per clock edge, sampled just after the edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.chk[0]) begin
          check({e.nm, "/q_a0"}, q_a0, e.qa0);
          check({e.nm, "/q_a1"}, q_a1, e.qa1);
        end
        if (e.chk[1]) begin
          check({e.nm, "/q_b0"}, q_b0, e.qb0);
          check({e.nm, "/q_b1"}, q_b1, e.qb1);
        end
        if (e.chk[2]) begin
          check({e.nm, "/busy0"}, {7'b0, busy0}, {7'b0, e.bz});
          check({e.nm, "/busy1"}, {7'b0, busy1}, {7'b0, e.bz});
        end
        if (e.chk[3]) begin
          check({e.nm, "/coll0"}, {7'b0, coll0}, {7'b0, e.co});
          check({e.nm, "/coll1"}, {7'b0, coll1}, {7'b0, e.co});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; clr_req = 1'b0;
    we_a = 1'b1; addr_a = 4'd0; data_a = 8'h00;
    we_b = 1'b1; addr_b = 4'd0; data_b = 8'h00;

    for (int i = 0; i < 3; i++)
      busy_step("reset", 1'b1, 1'b0, 1'b1, 4'd0, 8'h00, 1'b1, 4'd0, 8'h00, 1'b1);
    // Initial sweep: busy falls on the 16th edge after release
    for (int i = 0; i < 16; i++)
      busy_step("sweep1", 1'b0, 1'b0, 1'b1, 4'd0, 8'h00, 1'b1, 4'd0, 8'h00, (i < 15));
    for (int i = 0; i < 16; i++)
      rd("fill", 4'(i), 4'(15 - i), 8'hA5, 8'hA5);

    // Same-port read-during-write on A
    step("rdw_a", 1'b0, 1'b0, 1'b0, 4'd3, 8'h3C, 1'b1, 4'd0, 8'h00, C_ALL,
         8'h3C, 8'hA5, 8'hA5, 8'hA5, 1'b0, 1'b0);
    rd("rd3", 4'd3, 4'd3, 8'h3C, 8'h3C);

    // Double write to one address: A wins, collision pulses once
    step("dbl_wr", 1'b0, 1'b0, 1'b0, 4'd7, 8'h11, 1'b0, 4'd7, 8'h22, C_ALL,
         8'h11, 8'hA5, 8'h22, 8'hA5, 1'b0, 1'b1);
    rd("rd7", 4'd7, 4'd7, 8'h11, 8'h11);

    // Cross-port reads during the other port's write return old contents
    step("xport_b", 1'b0, 1'b0, 1'b0, 4'd9, 8'h55, 1'b1, 4'd9, 8'h00, C_ALL,
         8'h55, 8'hA5, 8'hA5, 8'hA5, 1'b0, 1'b0);
    rd("rd9", 4'd9, 4'd9, 8'h55, 8'h55);
    step("xport_a", 1'b0, 1'b0, 1'b1, 4'd4, 8'h00, 1'b0, 4'd4, 8'h66, C_ALL,
         8'hA5, 8'hA5, 8'h66, 8'hA5, 1'b0, 1'b0);
    rd("rd4", 4'd4, 4'd4, 8'h66, 8'h66);

    // Two writes to different addresses: no collision
    step("two_wr", 1'b0, 1'b0, 1'b0, 4'd10, 8'h31, 1'b0, 4'd11, 8'h42, C_ALL,
         8'h31, 8'hA5, 8'h42, 8'hA5, 1'b0, 1'b0);
    rd("rd10_11", 4'd10, 4'd11, 8'h31, 8'h42);

    // Write, request clear (with a discarded B write), reset at sweep cycle 5
    step("w77", 1'b0, 1'b0, 1'b0, 4'd2, 8'h77, 1'b1, 4'd2, 8'h00, C_ALL,
         8'h77, 8'hA5, 8'hA5, 8'hA5, 1'b0, 1'b0);
    rd("rd2", 4'd2, 4'd2, 8'h77, 8'h77);
    busy_step("clr", 1'b0, 1'b1, 1'b1, 4'd0, 8'h00, 1'b0, 4'd5, 8'h99, 1'b1);
    for (int i = 0; i < 4; i++)
      busy_step("sweep2", 1'b0, 1'b0, 1'b0, 4'd2, 8'hEE, 1'b0, 4'd5, 8'hDD, 1'b1);
    busy_step("rst_mid", 1'b1, 1'b0, 1'b0, 4'd2, 8'hEE, 1'b0, 4'd5, 8'hDD, 1'b1);
    for (int i = 0; i < 16; i++)
      busy_step("sweep3", 1'b0, ((i % 3) == 0), 1'b0, 4'd2, 8'hEE, 1'b0, 4'd2, 8'hDD, (i < 15));
    rd("post_clr_a", 4'd2, 4'd5, 8'hA5, 8'hA5);
    rd("post_clr_b", 4'd7, 4'd9, 8'hA5, 8'hA5);
    rd("post_clr_c", 4'd3, 4'd4, 8'hA5, 8'hA5);

    // clr_req held throughout a sweep does not stretch it
    step("w12", 1'b0, 1'b0, 1'b0, 4'd1, 8'h12, 1'b1, 4'd1, 8'h00, C_ALL,
         8'h12, 8'hA5, 8'hA5, 8'hA5, 1'b0, 1'b0);
    busy_step("clr2", 1'b0, 1'b1, 1'b1, 4'd0, 8'h00, 1'b1, 4'd0, 8'h00, 1'b1);
    for (int i = 0; i < 16; i++)
      busy_step("sweep4", 1'b0, 1'b1, 1'b0, 4'd1, 8'h5A, 1'b0, 4'd1, 8'h6B, (i < 15));
    rd("post_clr2", 4'd1, 4'd1, 8'hA5, 8'hA5);
    rd("post_clr3", 4'd10, 4'd11, 8'hA5, 8'hA5);

    @(posedge clk);
    #2;
    n_vec++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
